// File: rtl/pulse_sync_pkg.sv
// Shared constants for the toggle-based pulse synchronizer receiver.
// State encoding, default synchronizer depth and legal parameter ranges.
package pulse_sync_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    localparam int unsigned ACK_DLY_MIN = 1;
    localparam int unsigned ACK_DLY_MAX = 15;

    // Delay counter must hold ACK_DLY_MAX - 1.
    localparam int unsigned DLY_W = 4;

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer for asynchronous inputs entering a clock domain.
// Synchronous active-low reset clears the whole chain.
module sync_ff
    import pulse_sync_pkg::*;
#(
    parameter int unsigned N = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[N-2:0], d};
        end
    end

    assign q = chain[N-1];

endmodule

// File: rtl/pulse_sync_rx.sv
// Destination-side receiver of the toggle pulse synchronizer: one d_out pulse per
// source toggle, delayed ack toggle back to the source, event count and overrun flag.
module pulse_sync_rx
    import pulse_sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned ACK_DLY     = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk_dst,
    input  logic             rst_n,
    input  logic             tq,
    input  logic             clr_cnt,
    output logic             d_out,
    output logic             ack,
    output logic [CNT_W-1:0] rx_cnt,
    output logic             err_ovf
);

    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(ACK_DLY - 1);

    logic             tq_s;
    logic             tq_d;
    logic             tq_edge;
    logic             state;
    logic             state_nxt;
    logic [DLY_W-1:0] dly_cnt;
    logic [DLY_W-1:0] dly_nxt;
    logic             tq_d_nxt;
    logic             d_out_nxt;
    logic             ack_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             fire;
    logic             violation;

    sync_ff #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk   (clk_dst),
        .rst_n (rst_n),
        .d     (tq),
        .q     (tq_s)
    );

    // An unconsumed toggle shows up as a difference between tq_s and tq_d.
    assign tq_edge = tq_s ^ tq_d;

    always_ff @(posedge clk_dst) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (tq_edge) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (dly_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        fire      = 1'b0;
        violation = 1'b0;
        d_out_nxt = 1'b0;
        tq_d_nxt  = tq_d;
        dly_nxt   = dly_cnt;
        ack_nxt   = ack;
        case (state)
            ST_IDLE: begin
                if (tq_edge) begin
                    fire      = 1'b1;
                    d_out_nxt = 1'b1;
                    tq_d_nxt  = tq_s;
                    dly_nxt   = DLY_INIT;
                end
            end
            ST_HOLD: begin
                // A toggle arriving here stays pending and is consumed back in IDLE.
                violation = tq_edge;
                if (dly_cnt == '0) begin
                    ack_nxt = ~ack;
                end else begin
                    dly_nxt = dly_cnt - DLY_W'(1);
                end
            end
            default: ;
        endcase

        err_nxt = violation | (err_ovf & ~clr_cnt);

        if (clr_cnt) begin
            cnt_nxt = fire ? CNT_W'(1) : '0;
        end else begin
            cnt_nxt = rx_cnt + CNT_W'(fire);
        end
    end

    always_ff @(posedge clk_dst) begin
        if (!rst_n) begin
            tq_d    <= 1'b0;
            d_out   <= 1'b0;
            ack     <= 1'b0;
            dly_cnt <= '0;
            rx_cnt  <= '0;
            err_ovf <= 1'b0;
        end else begin
            tq_d    <= tq_d_nxt;
            d_out   <= d_out_nxt;
            ack     <= ack_nxt;
            dly_cnt <= dly_nxt;
            rx_cnt  <= cnt_nxt;
            err_ovf <= err_nxt;
        end
    end

endmodule
